// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_BURST_LEN = 2;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive denied DMA cycles, saturating at MAX_WAIT.
// Flags the denial that reaches the forced-window threshold.
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic starved
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] THR = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] SAT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;
  logic          denied;

  assign denied  = dma_req & ~dma_gnt;
  assign starved = denied & (wait_cnt == THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!denied) begin
      wait_cnt <= '0;
    end else if (wait_cnt != SAT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and a DMA/loader port.
// Core wins by default; a starved DMA gets a forced window.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CoreReq,
  input  logic          CoreWE,
  input  logic [AW-1:0] CoreA,
  input  logic [DW-1:0] CoreWD,
  output logic [DW-1:0] CoreRD,
  output logic          StallCore,
  input  logic          DmaReq,
  input  logic          DmaWE,
  input  logic [AW-1:0] DmaA,
  input  logic [DW-1:0] DmaWD,
  output logic          DmaAck,
  output logic [DW-1:0] DmaRD,
  output logic          MemWE,
  output logic [AW-1:0] MemA,
  output logic [DW-1:0] MemWD,
  input  logic [DW-1:0] MemRD,
  output logic          ForcedWin
);

  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_t    state, state_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic          core_gnt, dma_gnt;
  logic          starved;

  dmem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (CLK),
    .rst     (RST),
    .dma_req (DmaReq),
    .dma_gnt (dma_gnt),
    .starved (starved)
  );

  // In the forced window the core is locked out even if DMA idles.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!RST) begin
      unique case (state)
        ARB_CORE: begin
          core_gnt = CoreReq;
          dma_gnt  = ~CoreReq & DmaReq;
        end
        ARB_DMA: dma_gnt = DmaReq;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    burst_nx = burst_cnt;
    unique case (state)
      ARB_CORE: begin
        if (starved) begin
          state_nx = ARB_DMA;
          burst_nx = BW'(BURST_LEN);
        end
      end
      ARB_DMA: begin
        burst_nx = burst_cnt - BW'(1);
        if (burst_cnt == BW'(1) || !DmaReq) state_nx = ARB_CORE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ARB_CORE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
    end
  end

  assign DmaAck    = dma_gnt;
  assign StallCore = CoreReq & ~core_gnt & ~RST;
  assign MemA      = dma_gnt ? DmaA  : CoreA;
  assign MemWD     = dma_gnt ? DmaWD : CoreWD;
  assign MemWE     = (dma_gnt & DmaWE) | (core_gnt & CoreWE);
  assign CoreRD    = MemRD;
  assign DmaRD     = MemRD;
  assign ForcedWin = (state == ARB_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized
// run against a window/streak reference model and shadow memory.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int BL = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CoreReq, CoreWE, StallCore;
  logic [AW-1:0] CoreA;
  logic [DW-1:0] CoreWD, CoreRD;
  logic          DmaReq, DmaWE, DmaAck;
  logic [AW-1:0] DmaA;
  logic [DW-1:0] DmaWD, DmaRD;
  logic          MemWE, ForcedWin;
  logic [AW-1:0] MemA;
  logic [DW-1:0] MemWD, MemRD;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign MemRD = mem[MemA[11:2]];

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MW), .BURST_LEN(BL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CoreReq(CoreReq), .CoreWE(CoreWE), .CoreA(CoreA),
    .CoreWD(CoreWD), .CoreRD(CoreRD), .StallCore(StallCore),
    .DmaReq(DmaReq), .DmaWE(DmaWE), .DmaA(DmaA),
    .DmaWD(DmaWD), .DmaAck(DmaAck), .DmaRD(DmaRD),
    .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD),
    .MemRD(MemRD), .ForcedWin(ForcedWin)
  );

  task automatic drive(input logic rst, input logic creq,
                       input logic cwe, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic dreq,
                       input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    RST = rst; CoreReq = creq; CoreWE = cwe; CoreA = ca; CoreWD = cwd;
    DmaReq = dreq; DmaWE = dwe; DmaA = da; DmaWD = dwd;
  endtask

  // memory write lands on the rising edge; return at next negedge
  task automatic finish_cycle();
    logic       we;
    logic [9:0] idx;
    logic [31:0] wd;
    we = MemWE; idx = MemA[11:2]; wd = MemWD;
    @(posedge CLK);
    if (we) mem[idx] = wd;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    finish_cycle();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
    #2;
    checks++;
    if (DmaAck !== 1'b0) begin errors++;
      $display("FAIL rst_dack: got %b want 0", DmaAck); end
    checks++;
    if (StallCore !== 1'b0) begin errors++;
      $display("FAIL rst_stall: got %b want 0", StallCore); end
    checks++;
    if (MemWE !== 1'b0) begin errors++;
      $display("FAIL rst_memwe: got %b want 0", MemWE); end
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (ForcedWin !== 1'b0) begin errors++;
      $display("FAIL rst_forced: got %b want 0", ForcedWin); end
    finish_cycle();
  endtask

  task automatic test_core_only();
    mem[64] = 32'h12345678;
    drive(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (MemA !== 32'h100) begin errors++;
      $display("FAIL core_mema: got %h want 100", MemA); end
    checks++;
    if (CoreRD !== 32'h12345678) begin errors++;
      $display("FAIL core_rd: got %h want 12345678", CoreRD); end
    checks++;
    if (StallCore !== 1'b0) begin errors++;
      $display("FAIL core_stall: got %b want 0", StallCore); end
    checks++;
    if (MemWE !== 1'b0) begin errors++;
      $display("FAIL core_memwe: got %b want 0", MemWE); end
    finish_cycle();
  endtask

  task automatic test_dma_only();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
    #2;
    checks++;
    if (DmaAck !== 1'b1) begin errors++;
      $display("FAIL dma_ack: got %b want 1", DmaAck); end
    checks++;
    if (MemWE !== 1'b1) begin errors++;
      $display("FAIL dma_memwe: got %b want 1", MemWE); end
    checks++;
    if (MemWD !== 32'hDEADBEEF) begin errors++;
      $display("FAIL dma_memwd: got %h want deadbeef", MemWD); end
    finish_cycle();
    drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (CoreRD !== 32'hDEADBEEF) begin errors++;
      $display("FAIL wr_then_rd: got %h want deadbeef", CoreRD); end
    finish_cycle();
  endtask

  task automatic test_contention();
    logic e;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, 0, 32'h100, 0, 1, 0, 32'h40, 0);
      #2;
      e = ((c % 6) >= 4);
      checks++;
      if (DmaAck !== e) begin errors++;
        $display("FAIL cont_dack c%0d: got %b want %b", c, DmaAck, e); end
      checks++;
      if (StallCore !== e) begin errors++;
        $display("FAIL cont_stall c%0d: got %b want %b", c, StallCore, e); end
      checks++;
      if (ForcedWin !== e) begin errors++;
        $display("FAIL cont_forced c%0d: got %b want %b", c, ForcedWin, e); end
      finish_cycle();
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 1, 32'h200, 32'(c), (c < 4), 1, 32'h44, 32'hAA);
      #2;
      if (c < 4) begin
        checks++;
        if (DmaAck !== 1'b0 || StallCore !== 1'b0) begin errors++;
          $display("FAIL drop_pre c%0d: got ack=%b stall=%b want 0 0",
                   c, DmaAck, StallCore); end
      end else if (c == 4) begin
        checks++;
        if (DmaAck !== 1'b0) begin errors++;
          $display("FAIL drop_dack: got %b want 0", DmaAck); end
        checks++;
        if (MemWE !== 1'b0) begin errors++;
          $display("FAIL drop_memwe: got %b want 0", MemWE); end
        checks++;
        if (StallCore !== 1'b1) begin errors++;
          $display("FAIL drop_stall: got %b want 1", StallCore); end
        checks++;
        if (ForcedWin !== 1'b1) begin errors++;
          $display("FAIL drop_forced: got %b want 1", ForcedWin); end
      end else begin
        checks++;
        if (ForcedWin !== 1'b0 || StallCore !== 1'b0 || MemWE !== 1'b1)
        begin errors++;
          $display("FAIL drop_after: got fw=%b st=%b we=%b want 0 0 1",
                   ForcedWin, StallCore, MemWE); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive((c == 4), 1, 1, 32'h300, 32'(c), 1, 1, 32'h48, 32'hBB);
      #2;
      if (c == 4) begin
        checks++;
        if (DmaAck !== 1'b0 || MemWE !== 1'b0 || StallCore !== 1'b0)
        begin errors++;
          $display("FAIL midrst: got ack=%b we=%b st=%b want 0 0 0",
                   DmaAck, MemWE, StallCore); end
      end else if (c >= 5) begin
        e = (c == 9);
        checks++;
        if (DmaAck !== e || ForcedWin !== e || StallCore !== e)
        begin errors++;
          $display("FAIL midrst_post c%0d: got ack=%b fw=%b st=%b want %b",
                   c, DmaAck, ForcedWin, StallCore, e); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_interleave();
    logic creq;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      creq = ((c % 2) == 0);
      drive(0, creq, 0, 32'h100, 0, 1, 0, 32'h40, 0);
      #2;
      checks++;
      if (DmaAck !== !creq || StallCore !== 1'b0 || ForcedWin !== 1'b0)
      begin errors++;
        $display("FAIL ilv c%0d: got ack=%b st=%b fw=%b want %b 0 0",
                 c, DmaAck, StallCore, ForcedWin, !creq); end
      finish_cycle();
    end
  endtask

  task automatic test_random();
    int          streak, win;
    logic        rst, creq, cwe, dpend, dwe;
    logic [31:0] ca, cwd, da, dwd;
    logic        cg, dg, fw, we;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    streak = 0; win = 0; dpend = 0;
    dwe = 0; da = 0; dwd = 0;
    for (int n = 0; n < 2000; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      creq = ($urandom_range(0, 9) < 7);
      cwe  = ($urandom_range(0, 2) == 0);
      ca   = {20'h0, 10'($urandom), 2'b00};
      cwd  = $urandom;
      if (!dpend) begin
        if ($urandom_range(0, 1) == 1) begin
          dpend = 1;
          dwe = ($urandom_range(0, 1) == 1);
          da  = {20'h0, 10'($urandom), 2'b00};
          dwd = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        dpend = 0;
      end
      drive(rst, creq, cwe, ca, cwd, dpend, dwe, da, dwd);
      #2;
      fw = (win > 0);
      if (rst) begin
        cg = 0; dg = 0;
      end else if (win > 0) begin
        cg = 0; dg = dpend;
      end else begin
        cg = creq; dg = !creq && dpend;
      end
      we = (cg && cwe) || (dg && dwe);
      a  = dg ? da : ca;
      checks++;
      if (DmaAck !== dg) begin errors++;
        $display("FAIL rnd_dack n%0d: got %b want %b", n, DmaAck, dg); end
      checks++;
      if (StallCore !== (creq && !cg && !rst)) begin errors++;
        $display("FAIL rnd_stall n%0d: got %b want %b",
                 n, StallCore, creq && !cg && !rst); end
      checks++;
      if (ForcedWin !== fw) begin errors++;
        $display("FAIL rnd_forced n%0d: got %b want %b", n, ForcedWin, fw); end
      checks++;
      if (MemWE !== we) begin errors++;
        $display("FAIL rnd_memwe n%0d: got %b want %b", n, MemWE, we); end
      if (cg || dg) begin
        checks++;
        if (MemA !== a) begin errors++;
          $display("FAIL rnd_mema n%0d: got %h want %h", n, MemA, a); end
        if (we) begin
          checks++;
          if (MemWD !== (dg ? dwd : cwd)) begin errors++;
            $display("FAIL rnd_memwd n%0d: got %h want %h",
                     n, MemWD, dg ? dwd : cwd); end
          ref_mem[a[11:2]] = dg ? dwd : cwd;
        end else if (cg) begin
          checks++;
          if (CoreRD !== ref_mem[a[11:2]]) begin errors++;
            $display("FAIL rnd_corerd n%0d: got %h want %h",
                     n, CoreRD, ref_mem[a[11:2]]); end
        end else begin
          checks++;
          if (DmaRD !== ref_mem[a[11:2]]) begin errors++;
            $display("FAIL rnd_dmard n%0d: got %h want %h",
                     n, DmaRD, ref_mem[a[11:2]]); end
        end
      end
      if (rst) begin
        streak = 0; win = 0;
      end else if (win > 0) begin
        win = dpend ? win - 1 : 0;
      end else if (dpend && !dg) begin
        streak++;
        if (streak == MW) begin
          win = BL; streak = 0;
        end
      end else begin
        streak = 0;
      end
      if (dg) dpend = 0;
      finish_cycle();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    test_reset();
    test_core_only();
    test_dma_only();
    test_contention();
    test_drop();
    test_reset_mid();
    test_interleave();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core port) and a DMA/loader port (DMA port).
- The core has priority by default. A starvation counter forces a DMA window of BURST_LEN cycles after DMA has been denied for MAX_WAIT consecutive cycles. During that window the core is stalled.
- Sits between the MEM stage and the data memory. The memory has synchronous write and combinational read.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 4, consecutive denied DMA cycles that trigger a forced window (>=1).
- BURST_LEN, 2, maximum length of the forced DMA window in cycles (>=1).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- CoreReq  input  1  MEM stage has a load or store this cycle.
- CoreWE  input  1  core write enable (MemWriteM).
- CoreA  input  AW  core address (ALUResultM).
- CoreWD  input  DW  core write data.
- CoreRD  output  DW  read data to core (= MemRD).
- StallCore  output  1  core request not granted; the pipeline holds the MEM stage and everything before it.
- DmaReq  input  1  DMA request; held with stable A/WE/WD until DmaAck.
- DmaWE  input  1  DMA write enable.
- DmaA  input  AW  DMA address.
- DmaWD  input  DW  DMA write data.
- DmaAck  output  1  DMA access performed this cycle.
- DmaRD  output  DW  read data to DMA (= MemRD), valid when DmaAck=1.
- MemWE  output  1  to data memory WE.
- MemA  output  AW  to data memory A.
- MemWD  output  DW  to data memory WD.
- MemRD  input  DW  from data memory RD.
- ForcedWin  output  1  state is ARB_DMA (debug/perf).

Behaviour:
- Registered state: State {ARB_CORE, ARB_DMA}, WaitCnt (clog2(MAX_WAIT+1) bits), BurstCnt (clog2(BURST_LEN+1) bits). Reset values: ARB_CORE, 0, 0.
- Grants are combinational from State and the requests, with zero added latency. The access completes in the cycle it is granted.
- ARB_CORE:
  - CoreReq=1: core granted.
  - Otherwise, DmaReq=1: DMA granted.
- ARB_DMA:
  - DmaReq=1: DMA granted.
  - Otherwise: nobody granted. This holds even if CoreReq=1, so the core is stalled for that cycle.
- Outputs:
  - DmaAck = DMA granted.
  - StallCore = CoreReq & ~core granted.
  - MemA/MemWD = DMA fields when DMA granted, else core fields.
  - MemWE = granted requester's WE, else 0.
- WaitCnt:
  - Cleared on any DMA grant, or when DmaReq=0.
  - Otherwise increments (DmaReq & ~DmaAck), saturating at MAX_WAIT.
- Transitions:
  - ARB_CORE -> ARB_DMA when DmaReq & ~DmaAck & WaitCnt==MAX_WAIT-1. BurstCnt is loaded with BURST_LEN.
  - In ARB_DMA, BurstCnt decrements every cycle.
  - ARB_DMA -> ARB_CORE when BurstCnt==1 or DmaReq==0, evaluated in the current cycle.
- Timing: DMA is granted no later than cycle MAX_WAIT after first being denied (cycles counted from 0).
- While RST=1:
  - All grants forced to 0.
  - MemWE=0, StallCore=0, DmaAck=0.
  - State reloads reset values at the edge.
- Reset mid-window: returns to ARB_CORE at the next edge. There is no partial access, because writes occur only on granted edges.
- Read data: reads are combinational. CoreRD and DmaRD are both wired to MemRD; only the granted side may consume it.
- Write-then-read: a DMA write followed by a core read of the same address returns the new data on the next cycle.

Decomposition:
- Package dmem_arb_pkg:
  - State enum arb_state_t {ARB_CORE, ARB_DMA}.
  - Default MAX_WAIT and BURST_LEN constants.
- One sub-module, dmem_arb_starve_ctr:
  - Contains WaitCnt, saturation and the threshold compare.
  - Outputs a "starved" pulse.
  - Instantiated once.
- Grant mux and FSM remain in dmem_arbiter.

Test Plan:
- Core only: CoreReq=1, CoreWE=0, CoreA=0x100, memory[0x100]=0x12345678.
  - Same cycle: MemA=0x100, CoreRD=0x12345678, StallCore=0, MemWE=0.
- DMA only: DmaReq=1, DmaWE=1, DmaA=0x40, DmaWD=0xDEADBEEF, core idle.
  - Same cycle: DmaAck=1, MemWE=1.
  - Next cycle: core read of 0x40 returns 0xDEADBEEF.
- Continuous contention (MAX_WAIT=4, BURST_LEN=2):
  - Cycles 0-3: core granted, DmaAck=0.
  - Cycles 4-5: DmaAck=1, StallCore=1, ForcedWin=1.
  - Cycle 6: core granted.
  - Pattern repeats with period 6.
- DMA drops DmaReq at cycle 4 of the forced window:
  - Cycle 4: no grant, MemWE=0, StallCore=1.
  - Cycle 5: ARB_CORE, core granted.
- RST=1 asserted during cycle 4 (ARB_DMA):
  - Cycle 4: all grants 0, MemWE=0.
  - Cycle 5 (RST low): ARB_CORE, WaitCnt=0, core granted.
- DMA request interleaved with idle core cycles:
  - DMA granted in each idle core cycle.
  - WaitCnt cleared on each grant.
  - ARB_DMA never entered.
